// File: rtl/command_pkg.sv
// Shared types and helpers for the command scheduler.
// The scheduler top and its round-robin picker both use them.
package command_pkg;
    localparam int CMD_WIDTH = 16;

    typedef logic [CMD_WIDTH-1:0] cmd_word_t;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } sched_state_t;

    function automatic int src_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Finds the first set request bit at or after a start index.
// The search wraps modulo N.
module rr_pick
    import command_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = src_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(start) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/command_scheduler.sv
// Round-robin drain of NUM_SRC fall-through command FIFOs into one registered
// valid/ready output, with a per-source burst limit.
module command_scheduler
    import command_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 16,
    parameter  int BURST   = 2,
    localparam int SB      = src_bits(NUM_SRC),
    localparam int CW      = $clog2(BURST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         src_empty,
    input  logic [NUM_SRC*WIDTH-1:0]   src_command,
    output logic [NUM_SRC-1:0]         src_read,
    output logic [WIDTH-1:0]           cmd_out,
    output logic [SB-1:0]              cmd_src,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       busy
);
    sched_state_t     state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SB-1:0]    src_q, src_d;
    logic [SB-1:0]    ptr_q, ptr_d;   // last winner; search resumes after it
    logic [CW-1:0]    cnt_q, cnt_d;   // 0 only before the first grant after reset

    logic [NUM_SRC-1:0] req;
    logic [SB-1:0]      start, pick_idx, winner;
    logic               pick_found, slot_free, keep_last, grant;

    assign req = ~src_empty;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        slot_free = (state_q == S_EMPTY) || cmd_ready;
        keep_last = (cnt_q != '0) && req[ptr_q] && (cnt_q < CW'(BURST));
        if (cnt_q == '0)
            start = ptr_q;
        else
            start = (ptr_q == SB'(NUM_SRC - 1)) ? '0 : ptr_q + 1'b1;
        grant  = rst && enable && slot_free && (keep_last || pick_found);
        winner = keep_last ? ptr_q : pick_idx;

        src_read = '0;
        state_d  = state_q;
        out_d    = out_q;
        src_d    = src_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (grant) begin
            src_read[winner] = 1'b1;
            state_d = S_FULL;
            out_d   = src_command[int'(winner)*WIDTH +: WIDTH];
            src_d   = winner;
            ptr_d   = winner;
            // A sole non-empty source keeps winning; its count just saturates.
            if (cnt_q != '0 && winner == ptr_q)
                cnt_d = (cnt_q < CW'(BURST)) ? cnt_q + 1'b1 : cnt_q;
            else
                cnt_d = CW'(1);
        end else if (slot_free) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_out   = out_q;
    assign cmd_src   = src_q;
    assign cmd_valid = (state_q == S_FULL);
    assign busy      = cmd_valid || (|req);
endmodule
